sha512_msg_reader: RTL and testbench
====================================

SHA512_MSG_READER -- requirements
Module: sha512_msg_reader

Interface
REQ-001 SHALL have parameter WordW, default 64, meaning the message word and length-half width.
REQ-002 SHALL have port clk_i  input  1  clock; every flop samples on the rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sha_en  input  1  enable; low synchronously clears all state.
REQ-005 SHALL have port hash_start  input  1  one-cycle pulse that starts a new message.
REQ-006 SHALL have port hash_process  input  1  one-cycle pulse meaning every message word is already in the FIFO.
REQ-007 SHALL have port message_length  input  128  message length in bits, stable from hash_process until done.
REQ-008 SHALL have port fifo_rvalid  input  1  FIFO entry available.
REQ-009 SHALL have port fifo_rready  output  1  FIFO entry consumed in this cycle.
REQ-010 SHALL have port fifo_rdata  input  72  packed FIFO entry: bits [71:64] are the byte mask and bits [63:0] are the data.
REQ-011 SHALL have port word_valid  output  1  padded word is presented.
REQ-012 SHALL have port word_ready  input  1  compression core accepts the word.
REQ-013 SHALL have port word_data  output  64  padded big-endian message word.
REQ-014 SHALL have port block_end  output  1  the presented word is word 15 of a 1024-bit block.
REQ-015 SHALL have port msg_last  output  1  the presented word is the final word of the message.
REQ-016 SHALL have port done  output  1  one-cycle pulse when the message is complete.

Function
REQ-017 Mask bit 7 SHALL qualify data[63:56] and mask bit 0 SHALL qualify data[7:0]; a partial mask SHALL be contiguous from bit 7.
REQ-018 The FSM SHALL have the states IDLE, DATA, PAD0, LENHI and LENLO.
REQ-019 A word transfer SHALL occur in any cycle where word_valid and word_ready are both high.
REQ-020 Bits word_idx[3:0] SHALL increment on each transfer and SHALL wrap from 15 to 0.
REQ-021 block_end SHALL equal word_valid & (word_idx==15).
REQ-022 hash_start with sha_en high SHALL, from any state, go to DATA, clear word_idx and clear the latched process flag.
REQ-023 hash_process SHALL set the process flag.
REQ-024 In DATA, for an entry with mask 0xFF: word_valid = fifo_rvalid, word_data = data, fifo_rready = word_ready; the entry passes through with zero cycles of latency.
REQ-025 In DATA, an entry with mask 0x00 SHALL be popped with fifo_rready=1, SHALL produce no word and SHALL not change word_idx.
REQ-026 In DATA, an entry with a partial mask SHALL be emitted with unmasked bytes zeroed and 0x80 in the first unmasked byte; the FSM then goes to PAD0.
REQ-027 In DATA, when the process flag is set and fifo_rvalid=0, the FSM SHALL present 0x8000_0000_0000_0000 and SHALL go to PAD0 on the transfer.
REQ-028 In PAD0, the block SHALL present zero words until the next transfer index is 14, then go to LENHI.
REQ-029 If the 0x80 word transfers at index 14 or 15, PAD0 SHALL pad the rest of the block with zeros, then 14 zeros of a new block, then go to LENHI.
REQ-030 LENHI SHALL present message_length[127:64].
REQ-031 LENLO SHALL present message_length[63:0] with msg_last=1.
REQ-032 The LENLO transfer SHALL move the FSM to IDLE and SHALL pulse done in the following cycle.
REQ-033 fifo_rready SHALL be 0 outside DATA.
REQ-034 After a partial entry, the FIFO SHALL not be popped again until the next hash_start.
REQ-035 While word_valid=1 and word_ready=0, word_data, block_end and msg_last SHALL hold stable.
REQ-036 In IDLE, word_valid SHALL be 0, and hash_process SHALL be ignored.
REQ-037 When hash_start and hash_process arrive in the same cycle, the message SHALL be treated as empty if fifo_rvalid=0 in the next cycle.

Reset
REQ-038 Asserting rst_ni low SHALL put the FSM in IDLE, set word_idx=0, clear the process flag, and hold fifo_rready, word_valid, block_end, msg_last and done at 0.
REQ-039 sha_en=0 SHALL have the same effect synchronously, including mid-message; done SHALL not pulse.

Verification
REQ-040 Empty message (start, process, FIFO empty, length 0) SHALL produce 16 words: 0x8000000000000000, 13 zeros, 0, 0; block_end and msg_last high on word 15; done one cycle later.
REQ-041 "abc" (entry mask 0xE0, data 0x6162630000000000, length 24) SHALL produce word0 0x6162638000000000, 13 zeros, 0, 0x18.
REQ-042 14 full-mask words with length 896 SHALL produce 32 words: data 0..13, 0x80 word at index 14, zero at 15 with block_end, 14 zeros, 0, 0x380 with msg_last.
REQ-043 Holding word_ready low for 3 cycles at PAD0 index 5 SHALL keep word_data=0 and word_idx=5, with no FIFO pop.
REQ-044 Dropping sha_en during LENHI SHALL go to IDLE next cycle with word_valid=0 and no done pulse.
REQ-045 A mask-0x00 entry between data words SHALL be popped with no word emitted and no change to word_idx.

Source files
------------

// File: rtl/sha512_msg_reader.sv
// SHA-512 message reader: pulls byte-masked words from a FIFO and presents
// the padded message (data, 0x80 marker, zero fill, 128-bit length) to the
// compression core one word at a time, tagging block ends and the final word.
//
// Handshake: a word moves to the core in every cycle where word_valid and
// word_ready are both high; while word_valid is high and word_ready is low,
// word_data, block_end and msg_last hold stable. A FIFO entry is consumed in
// every cycle where fifo_rvalid and fifo_rready are both high; fifo_rready is
// only ever high in DATA.
module sha512_msg_reader #(
  parameter int WordW = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     sha_en,
  input  logic                     hash_start,
  input  logic                     hash_process,
  input  logic [2*WordW-1:0]       message_length,
  input  logic                     fifo_rvalid,
  output logic                     fifo_rready,
  input  logic [WordW+WordW/8-1:0] fifo_rdata,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [WordW-1:0]         word_data,
  output logic                     block_end,
  output logic                     msg_last,
  output logic                     done,
  output logic [2:0]               dbg_state_o,
  output logic [3:0]               dbg_word_idx_o
);

  localparam int NB = WordW / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_PAD0  = 3'd2,
    ST_LENHI = 3'd3,
    ST_LENLO = 3'd4
  } state_e;

  state_e     state_q;
  logic [3:0] word_idx_q;
  logic       proc_q;
  logic       done_q;

  logic [NB-1:0]    entry_mask;
  logic [WordW-1:0] entry_data;
  logic [WordW-1:0] pad_data;
  logic             pad_word;
  logic             xfer;
  logic             prev_valid;

  assign entry_mask = fifo_rdata[WordW +: NB];
  assign entry_data = fifo_rdata[WordW-1:0];

  // Partial entry: keep masked bytes, put 0x80 in the first unmasked byte.
  always_comb begin
    pad_data   = '0;
    prev_valid = 1'b1;
    for (int b = 0; b < NB; b++) begin
      if (entry_mask[NB-1-b]) begin
        pad_data[WordW-1-8*b -: 8] = entry_data[WordW-1-8*b -: 8];
      end else if (prev_valid) begin
        pad_data[WordW-1-8*b -: 8] = 8'h80;
      end
      prev_valid = entry_mask[NB-1-b];
    end
  end

  // Word presentation and FIFO pop, combinational so data passes with no latency.
  always_comb begin
    word_valid  = 1'b0;
    word_data   = '0;
    fifo_rready = 1'b0;
    msg_last    = 1'b0;
    pad_word    = 1'b0;
    if (sha_en) begin
      case (state_q)
        ST_DATA: begin
          if (fifo_rvalid) begin
            if (&entry_mask) begin
              word_valid  = 1'b1;
              word_data   = entry_data;
              fifo_rready = word_ready;
            end else if (entry_mask == '0) begin
              // Empty entry: drop it without producing a word.
              fifo_rready = 1'b1;
            end else begin
              word_valid  = 1'b1;
              word_data   = pad_data;
              fifo_rready = word_ready;
              pad_word    = 1'b1;
            end
          end else if (proc_q) begin
            word_valid = 1'b1;
            word_data  = {8'h80, {(WordW-8){1'b0}}};
            pad_word   = 1'b1;
          end
        end
        ST_PAD0: begin
          word_valid = 1'b1;
        end
        ST_LENHI: begin
          word_valid = 1'b1;
          word_data  = message_length[2*WordW-1:WordW];
        end
        ST_LENLO: begin
          word_valid = 1'b1;
          word_data  = message_length[WordW-1:0];
          msg_last   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign xfer           = word_valid & word_ready;
  assign block_end      = word_valid & (word_idx_q == 4'd15);
  assign done           = done_q;
  assign dbg_state_o    = state_q;
  assign dbg_word_idx_o = word_idx_q;

  // Message FSM: word index, latched process flag and done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      word_idx_q <= 4'd0;
      proc_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (!sha_en) begin
      state_q    <= ST_IDLE;
      word_idx_q <= 4'd0;
      proc_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (hash_start) begin
        // A process pulse in the same cycle still counts for this message.
        state_q    <= ST_DATA;
        word_idx_q <= 4'd0;
        proc_q     <= hash_process;
      end else begin
        if (hash_process && (state_q != ST_IDLE)) begin
          proc_q <= 1'b1;
        end
        if (xfer) begin
          word_idx_q <= word_idx_q + 4'd1;
        end
        case (state_q)
          ST_DATA: begin
            // If the marker lands on index 13 there is no zero fill left.
            if (xfer && pad_word) begin
              state_q <= (word_idx_q == 4'd13) ? ST_LENHI : ST_PAD0;
            end
          end
          ST_PAD0: begin
            if (xfer && (word_idx_q == 4'd13)) begin
              state_q <= ST_LENHI;
            end
          end
          ST_LENHI: begin
            if (xfer) begin
              state_q <= ST_LENLO;
            end
          end
          ST_LENLO: begin
            if (xfer) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha512_msg_reader.sv
// Directed bench for sha512_msg_reader: FIFO model, negedge monitor, one task per scenario.
module tb_sha512_msg_reader;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PAD0  = 3'd2;
  localparam logic [2:0] S_LENHI = 3'd3;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         sha_en;
  logic         hash_start;
  logic         hash_process;
  logic [127:0] message_length;
  logic         fifo_rvalid;
  logic         fifo_rready;
  logic [71:0]  fifo_rdata;
  logic         word_valid;
  logic         word_ready;
  logic [63:0]  word_data;
  logic         block_end;
  logic         msg_last;
  logic         done;
  logic [2:0]   dbg_state_o;
  logic [3:0]   dbg_word_idx_o;

  sha512_msg_reader #(.WordW(64)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sha_en         (sha_en),
    .hash_start     (hash_start),
    .hash_process   (hash_process),
    .message_length (message_length),
    .fifo_rvalid    (fifo_rvalid),
    .fifo_rready    (fifo_rready),
    .fifo_rdata     (fifo_rdata),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .word_data      (word_data),
    .block_end      (block_end),
    .msg_last       (msg_last),
    .done           (done),
    .dbg_state_o    (dbg_state_o),
    .dbg_word_idx_o (dbg_word_idx_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [71:0] fifo_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic        got_be[$];
  logic        got_ml[$];
  int cyc = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  int last_xfer_cyc = 0;
  int done_cyc = 0;

  task automatic fifo_refresh();
    fifo_rvalid = (fifo_q.size() != 0);
    fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 72'h0;
  endtask

  // FIFO model: pop on a consumed entry, then present the new head.
  always @(posedge clk_i) begin
    cyc++;
    if (fifo_rvalid && fifo_rready && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
    #1 fifo_refresh();
  end

  // Monitor: transfers, done pulses and pops, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (word_valid && word_ready) begin
      got_q.push_back(word_data);
      got_be.push_back(block_end);
      got_ml.push_back(msg_last);
      last_xfer_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (fifo_rvalid && fifo_rready) pop_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_be.delete();
    got_ml.delete();
    exp_q.delete();
  endtask

  task automatic start_msg(input logic with_process);
    hash_start   = 1'b1;
    hash_process = with_process;
    tick();
    hash_start   = 1'b0;
    hash_process = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n0;
    n0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sha_en = 1'b1; hash_start = 1'b0; hash_process = 1'b0;
    word_ready = 1'b0; message_length = '0;
    fifo_q.push_back({8'hFF, 64'h1122_3344_5566_7788});
    fifo_refresh();
    rst_ni = 1'b0;
    #12;
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rst_word_valid: got %b want 0", word_valid); end
    total++; if (fifo_rready !== 1'b0) begin bad++; $display("FAIL rst_fifo_rready: got %b want 0", fifo_rready); end
    total++; if (block_end !== 1'b0 || msg_last !== 1'b0) begin bad++; $display("FAIL rst_flags: got be=%b last=%b want 0 0", block_end, msg_last); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (dbg_state_o !== S_IDLE || dbg_word_idx_o !== 4'd0) begin bad++; $display("FAIL rst_state: got st=%0d idx=%0d want 0 0", dbg_state_o, dbg_word_idx_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    // Process pulse in IDLE must be ignored and IDLE must not pop the FIFO.
    hash_process = 1'b1; word_ready = 1'b1;
    tick();
    hash_process = 1'b0;
    tick();
    total++; if (dbg_state_o !== S_IDLE || word_valid !== 1'b0) begin bad++; $display("FAIL idle_process: got st=%0d valid=%b want 0 0", dbg_state_o, word_valid); end
    total++; if (fifo_rready !== 1'b0 || pop_cnt !== 0) begin bad++; $display("FAIL idle_no_pop: got rready=%b pops=%0d want 0 0", fifo_rready, pop_cnt); end
    fifo_q.delete();
    fifo_refresh();
    tick();
  endtask

  task automatic test_empty();
    bit ok;
    clear_obs();
    message_length = '0; word_ready = 1'b1;
    start_msg(1'b1);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL empty_timeout: got no done want done"); end
    total++; if (done_cyc != last_xfer_cyc + 1) begin bad++; $display("FAIL empty_done_timing: got cyc %0d want %0d", done_cyc, last_xfer_cyc + 1); end
    exp_q.push_back(64'h8000_0000_0000_0000);
    for (int i = 0; i < 15; i++) exp_q.push_back(64'h0);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL empty_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL empty_word[%0d]: got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i] || got_be[i] !== (i % 16 == 15) || got_ml[i] !== (i == exp_q.size() - 1)) begin
        bad++; $display("FAIL empty_word[%0d]: got %h be=%b last=%b want %h be=%b last=%b", i, got_q[i], got_be[i], got_ml[i], exp_q[i], (i % 16 == 15), (i == exp_q.size() - 1));
      end
    end
    tick();
  endtask

  task automatic test_abc();
    bit ok;
    int p0;
    clear_obs();
    message_length = 128'd24; word_ready = 1'b1;
    fifo_q.push_back({8'hE0, 64'h6162_6300_0000_0000});
    fifo_refresh();
    p0 = pop_cnt;
    start_msg(1'b0);
    hash_process = 1'b1;
    tick();
    hash_process = 1'b0;
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL abc_timeout: got no done want done"); end
    total++; if (done_cyc != last_xfer_cyc + 1) begin bad++; $display("FAIL abc_done_timing: got cyc %0d want %0d", done_cyc, last_xfer_cyc + 1); end
    total++; if (pop_cnt - p0 != 1) begin bad++; $display("FAIL abc_pops: got %0d want 1", pop_cnt - p0); end
    exp_q.push_back(64'h6162_6380_0000_0000);
    for (int i = 0; i < 14; i++) exp_q.push_back(64'h0);
    exp_q.push_back(64'h18);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL abc_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL abc_word[%0d]: got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i] || got_be[i] !== (i % 16 == 15) || got_ml[i] !== (i == exp_q.size() - 1)) begin
        bad++; $display("FAIL abc_word[%0d]: got %h be=%b last=%b want %h be=%b last=%b", i, got_q[i], got_be[i], got_ml[i], exp_q[i], (i % 16 == 15), (i == exp_q.size() - 1));
      end
    end
    tick();
  endtask

  task automatic test_full14();
    bit ok;
    int p0;
    clear_obs();
    message_length = 128'd896; word_ready = 1'b1;
    for (int i = 0; i < 14; i++) fifo_q.push_back({8'hFF, 64'hA5A5_0000_0000_0000 + 64'(i)});
    fifo_refresh();
    p0 = pop_cnt;
    start_msg(1'b0);
    hash_process = 1'b1;
    tick();
    hash_process = 1'b0;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL full14_timeout: got no done want done"); end
    total++; if (pop_cnt - p0 != 14) begin bad++; $display("FAIL full14_pops: got %0d want 14", pop_cnt - p0); end
    for (int i = 0; i < 14; i++) exp_q.push_back(64'hA5A5_0000_0000_0000 + 64'(i));
    exp_q.push_back(64'h8000_0000_0000_0000);
    for (int i = 0; i < 16; i++) exp_q.push_back(64'h0);
    exp_q.push_back(64'h380);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL full14_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL full14_word[%0d]: got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i] || got_be[i] !== (i % 16 == 15) || got_ml[i] !== (i == exp_q.size() - 1)) begin
        bad++; $display("FAIL full14_word[%0d]: got %h be=%b last=%b want %h be=%b last=%b", i, got_q[i], got_be[i], got_ml[i], exp_q[i], (i % 16 == 15), (i == exp_q.size() - 1));
      end
    end
    tick();
  endtask

  task automatic test_mask_zero();
    bit ok;
    int p0;
    clear_obs();
    message_length = 128'd128; word_ready = 1'b1;
    fifo_q.push_back({8'hFF, 64'h0123_4567_89AB_CDEF});
    fifo_q.push_back({8'h00, 64'hFFFF_FFFF_FFFF_FFFF});
    fifo_q.push_back({8'hFF, 64'hFEDC_BA98_7654_3210});
    fifo_refresh();
    p0 = pop_cnt;
    start_msg(1'b0);
    hash_process = 1'b1;
    tick();
    hash_process = 1'b0;
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL mask0_timeout: got no done want done"); end
    total++; if (pop_cnt - p0 != 3) begin bad++; $display("FAIL mask0_pops: got %0d want 3", pop_cnt - p0); end
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    exp_q.push_back(64'hFEDC_BA98_7654_3210);
    exp_q.push_back(64'h8000_0000_0000_0000);
    for (int i = 0; i < 12; i++) exp_q.push_back(64'h0);
    exp_q.push_back(64'h80);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL mask0_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL mask0_word[%0d]: got none want %h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i] || got_be[i] !== (i % 16 == 15) || got_ml[i] !== (i == exp_q.size() - 1)) begin
        bad++; $display("FAIL mask0_word[%0d]: got %h be=%b last=%b want %h be=%b last=%b", i, got_q[i], got_be[i], got_ml[i], exp_q[i], (i % 16 == 15), (i == exp_q.size() - 1));
      end
    end
    tick();
  endtask

  task automatic test_stall();
    bit ok;
    bit found;
    int p0;
    clear_obs();
    message_length = '0; word_ready = 1'b1;
    start_msg(1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dbg_state_o == S_PAD0 && dbg_word_idx_o == 4'd5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++; if (!found) begin bad++; $display("FAIL stall_reach: got st=%0d idx=%0d want PAD0 idx 5", dbg_state_o, dbg_word_idx_o); end
    // A waiting FIFO entry must not be popped outside DATA.
    word_ready = 1'b0;
    fifo_q.push_back({8'hFF, 64'hDEAD_0000_0000_0001});
    fifo_refresh();
    p0 = pop_cnt;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (word_valid !== 1'b1 || word_data !== 64'h0 || dbg_word_idx_o !== 4'd5 || fifo_rready !== 1'b0) begin
        bad++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h idx=%0d rready=%b want 1 0 5 0", k, word_valid, word_data, dbg_word_idx_o, fifo_rready);
      end
      tick();
    end
    word_ready = 1'b1;
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: got no done want done"); end
    total++; if (got_q.size() != 16 || pop_cnt != p0) begin bad++; $display("FAIL stall_words: got %0d words %0d pops want 16 0", got_q.size(), pop_cnt - p0); end
    fifo_q.delete();
    fifo_refresh();
    tick();
  endtask

  task automatic test_sha_en_drop();
    bit found;
    int d0;
    clear_obs();
    message_length = {64'hDEAD_BEEF_0000_0001, 64'h0}; word_ready = 1'b1;
    d0 = done_cnt;
    start_msg(1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dbg_state_o == S_LENHI) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++; if (!found || word_data !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL lenhi_data: got st=%0d data=%h want LENHI dead_beef_0000_0001", dbg_state_o, word_data); end
    sha_en = 1'b0;
    tick();
    sha_en = 1'b1;
    total++; if (dbg_state_o !== S_IDLE || word_valid !== 1'b0 || dbg_word_idx_o !== 4'd0) begin bad++; $display("FAIL en_drop_state: got st=%0d valid=%b idx=%0d want 0 0 0", dbg_state_o, word_valid, dbg_word_idx_o); end
    for (int i = 0; i < 4; i++) tick();
    total++; if (done_cnt != d0 || word_valid !== 1'b0) begin bad++; $display("FAIL en_drop_done: got %0d done pulses valid=%b want 0 0", done_cnt - d0, word_valid); end
  endtask

  initial begin
    fifo_rvalid = 1'b0;
    fifo_rdata  = '0;
    test_reset();
    test_empty();
    test_abc();
    test_full14();
    test_mask_zero();
    test_stall();
    test_sha_en_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
